axis_frame_sink: RTL and testbench
==================================

# axis_frame_sink

Receiving end of the packed-pixel AXI-Stream video interface. The block consumes 32-bit packed pixel words framed by tuser (start of frame) and tlast (end of line), and tracks word and line position. It checks every frame against the configured geometry, reports framing errors and frame counts, and can accumulate a per-frame data checksum. It sits on the stream output of the pixel generator / packer path as a bench and bring-up monitor, or in front of a DMA as a frame-integrity gate.

## Interface
- WORDS_PER_LINE, default 480: 32-bit words per line (640 px × 24 bit / 32).
- LINES, default 480: lines per frame.
- CNT_W, default 16: width of frame and error counters.
- aclk  in  1  stream clock; all logic on rising edge.
- aresetn  in  1  reset; one clock; reset is asynchronous and active-low.
- in_stream_tdata  in  32  packed pixel word.
- in_stream_tkeep  in  4  byte enables; must be 4'hF.
- in_stream_tlast  in  1  end of line.
- in_stream_tuser  in  1  start of frame, on first word only.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  sink ready.
- enable_i  in  1  allows acceptance; low applies backpressure.
- clear_i  in  1  one-cycle pulse; clears sticky errors and counters.
- frame_done_o  out  1  one-cycle pulse per good frame.
- frame_count_o  out  CNT_W  good frames since reset/clear, wraps.
- error_count_o  out  CNT_W  error events, saturates at all-ones.
- err_flags_o  out  4  sticky: [0] early_eol, [1] late_eol, [2] unexpected_sof, [3] bad_keep.
- in_frame_o  out  1  high while in IN_FRAME.
- frame_sum_o  out  32  checksum of last good frame.

## Operation
- A word is accepted only on tvalid & tready. All state changes are gated by acceptance.
- States: SEEK_SOF (reset state) and IN_FRAME.
- SEEK_SOF: accepted words without tuser are discarded. An accepted word with tuser starts a frame: word counter wcnt=1, line counter lcnt=0, go IN_FRAME. The same word's tlast is checked as in IN_FRAME.
- IN_FRAME, per accepted word, in priority order:
  - tuser=1: unexpected_sof. The word restarts the frame (wcnt=1, lcnt=0), stay IN_FRAME.
  - tkeep≠4'hF: bad_keep. Go SEEK_SOF.
  - tlast=1 and wcnt≠WORDS_PER_LINE-1: early_eol. Go SEEK_SOF.
  - wcnt=WORDS_PER_LINE-1 and tlast=0: late_eol. Go SEEK_SOF.
  - Otherwise, at end of line: wcnt=0 and lcnt++. If lcnt=LINES-1, the frame is good: frame_count++, pulse frame_done, go SEEK_SOF.
- Each error sets its sticky flag and increments error_count by exactly 1. Only one error is flagged per word (the highest priority).
- Good frame at end of line: the tuser check is done first, so a word with tuser never completes a frame.
- clear_i: zeroes counters and flags, and does not change the state. If clear_i coincides with an increment, the clear wins.
- Widths: wcnt is $clog2(WORDS_PER_LINE) bits and lcnt is $clog2(LINES) bits. Compare against parameter-1 and never rely on natural wrap.

## Timing
- Reset values: in_stream_tready=0, frame_done_o=0, counters=0, err_flags_o=0, in_frame_o=0, frame_sum_o=0, state=SEEK_SOF.
- in_stream_tready is registered from enable_i, so there is 1 cycle of latency from enable_i to tready. tready never depends combinationally on tvalid.
- Status outputs are registered and update the cycle after the accepting edge. frame_done_o is high for exactly one cycle.
- Back-to-back frames need no idle cycles: the SOF word may arrive on the cycle after the frame's last word.
- A reset asserted mid-frame returns all state to reset values immediately. Remaining words are discarded until the next tuser.

## Configuration
- AXIS_SINK_CHECKSUM_EN defined:
  - A 32-bit modulo-2^32 sum of tdata is accumulated over the accepted words of the current frame, and reloads with tdata on the SOF word.
  - The sum is latched into frame_sum_o on the same edge that pulses frame_done_o.
  - An error discards the partial sum.
- Undefined: frame_sum_o is tied to 0 and no accumulator is built.

## Structure
- Package video_sink_pkg: state enum (SEEK_SOF, IN_FRAME), error bit index constants, default geometry constants (X_SIZE=640, Y_SIZE=480, WORDS_PER_LINE=480).
- One sub-module, frame_checksum (accumulator with load, add and latch controls). It is instantiated only under AXIS_SINK_CHECKSUM_EN.

## Test plan
All scenarios use WORDS_PER_LINE=4, LINES=3, enable_i=1 unless stated.
- Clean frame of 12 words, tdata=1, correct tuser/tlast → one frame_done_o pulse, frame_count_o=1, err_flags_o=0, frame_sum_o=12 (checksum build).
- tlast on word 2 of line 1 → err_flags_o=4'b0001, error_count_o=1, in_frame_o=0. Following clean frame → frame_count_o=1.
- tuser on word 6 → err_flags_o[2]=1. The frame restarts at that word, and 12 further good words from it → frame_count_o=1.
- 3 junk words without tuser, then a clean frame → junk discarded, frame_count_o=1, error_count_o=0.
- enable_i toggled randomly with tvalid held → no word lost or duplicated, sum still 12. tready follows enable_i with 1-cycle lag.
- aresetn asserted after word 7, then a clean frame → all outputs at reset values during reset, then frame_count_o=1.

Source files
------------

// File: rtl/video_sink_pkg.sv
// Shared types and constants for the packed-pixel AXI-Stream frame sink.
package video_sink_pkg;

    typedef enum logic {
        SEEK_SOF = 1'b0,
        IN_FRAME = 1'b1
    } sink_state_e;

    localparam int ERR_EARLY_EOL = 0;
    localparam int ERR_LATE_EOL  = 1;
    localparam int ERR_UNEXP_SOF = 2;
    localparam int ERR_BAD_KEEP  = 3;
    localparam int ERR_W         = 4;

    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    localparam int X_SIZE         = 640;
    localparam int Y_SIZE         = 480;
    localparam int BITS_PER_PIXEL = 24;
    localparam int WORDS_PER_LINE = X_SIZE * BITS_PER_PIXEL / DATA_W;

endpackage

// File: rtl/frame_checksum.sv
// Per-frame modulo-2^32 data accumulator: load on SOF, add per word,
// latch the completed sum (including the current word) on frame end.
module frame_checksum
    import video_sink_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_add,
    input  logic              i_latch,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_next;

    assign w_next = r_acc + i_data;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            if (i_load) begin
                r_acc <= i_data;
            end else if (i_add) begin
                r_acc <= w_next;
            end
            if (i_latch) begin
                r_sum <= w_next;
            end
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/axis_frame_sink.sv
// AXI-Stream video frame sink: geometry checker, error/frame counters and an
// optional per-frame checksum enabled by defining AXIS_SINK_CHECKSUM_EN.
module axis_frame_sink #(
    parameter int WORDS_PER_LINE = video_sink_pkg::WORDS_PER_LINE,
    parameter int LINES          = video_sink_pkg::Y_SIZE,
    parameter int CNT_W          = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      in_stream_tdata,
    input  logic [3:0]       in_stream_tkeep,
    input  logic             in_stream_tlast,
    input  logic             in_stream_tuser,
    input  logic             in_stream_tvalid,
    output logic             in_stream_tready,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_count_o,
    output logic [CNT_W-1:0] error_count_o,
    output logic [3:0]       err_flags_o,
    output logic             in_frame_o,
    output logic [31:0]      frame_sum_o
);
    import video_sink_pkg::*;

    localparam int WCNT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LCNT_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);
    localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(LINES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    sink_state_e       r_state;
    logic              r_tready;
    logic [WCNT_W-1:0] r_wcnt;
    logic [LCNT_W-1:0] r_lcnt;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_frame_count;
    logic [CNT_W-1:0]  r_error_count;
    logic [ERR_W-1:0]  r_err_flags;

    logic              w_accept;
    logic [ERR_W-1:0]  w_err;
    logic              w_load;
    logic              w_add;
    logic              w_good;

    assign w_accept = in_stream_tvalid & r_tready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the decode can leave a latch behind.
    always_comb begin
        w_err  = '0;
        w_load = 1'b0;
        w_add  = 1'b0;
        w_good = 1'b0;
        if (w_accept) begin
            if (r_state == SEEK_SOF) begin
                // The SOF word is position 0 of line 0; lines are at least two words.
                if (in_stream_tuser) begin
                    if (in_stream_tlast) w_err[ERR_EARLY_EOL] = 1'b1;
                    else                 w_load = 1'b1;
                end
            end else if (in_stream_tuser) begin
                w_err[ERR_UNEXP_SOF] = 1'b1;
                w_load               = 1'b1;
            end else if (in_stream_tkeep != KEEP_ALL) begin
                w_err[ERR_BAD_KEEP] = 1'b1;
            end else if (in_stream_tlast && (r_wcnt != LAST_WORD)) begin
                w_err[ERR_EARLY_EOL] = 1'b1;
            end else if (!in_stream_tlast && (r_wcnt == LAST_WORD)) begin
                w_err[ERR_LATE_EOL] = 1'b1;
            end else begin
                w_add  = 1'b1;
                w_good = in_stream_tlast && (r_lcnt == LAST_LINE);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= SEEK_SOF;
            r_tready      <= 1'b0;
            r_wcnt        <= '0;
            r_lcnt        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_error_count <= '0;
            r_err_flags   <= '0;
        end else begin
            r_tready     <= enable_i;
            r_frame_done <= w_good;

            if (w_load) begin
                r_state <= IN_FRAME;
                r_wcnt  <= WCNT_W'(1);
                r_lcnt  <= '0;
            end else if (|w_err) begin
                r_state <= SEEK_SOF;
            end else if (w_add) begin
                if (in_stream_tlast) begin
                    r_wcnt <= '0;
                    if (r_lcnt == LAST_LINE) begin
                        r_lcnt  <= '0;
                        r_state <= SEEK_SOF;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end

            // Clear takes precedence over any increment landing on the same edge.
            if (clear_i) begin
                r_frame_count <= '0;
                r_error_count <= '0;
                r_err_flags   <= '0;
            end else begin
                if (w_good) r_frame_count <= r_frame_count + 1'b1;
                if (|w_err) begin
                    r_err_flags <= r_err_flags | w_err;
                    if (r_error_count != CNT_MAX) r_error_count <= r_error_count + 1'b1;
                end
            end
        end
    end

`ifdef AXIS_SINK_CHECKSUM_EN
    frame_checksum u_checksum (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_load  (w_load),
        .i_add   (w_add),
        .i_latch (w_good),
        .i_data  (in_stream_tdata),
        .o_sum   (frame_sum_o)
    );
`else
    logic w_unused_tdata;
    assign w_unused_tdata = ^in_stream_tdata;
    assign frame_sum_o    = '0;
`endif

    assign in_stream_tready = r_tready;
    assign frame_done_o     = r_frame_done;
    assign frame_count_o    = r_frame_count;
    assign error_count_o    = r_error_count;
    assign err_flags_o      = r_err_flags;
    assign in_frame_o       = (r_state == IN_FRAME);

endmodule

// File: tb/tb_axis_frame_sink.sv
// Randomized bench for axis_frame_sink against a linear-position frame model.
module tb_axis_frame_sink;
    import video_sink_pkg::*;

    localparam int WPL = 4;
    localparam int NL  = 3;
    localparam int CW  = 16;
    localparam int FW  = WPL * NL;

    logic          aclk;
    logic          aresetn;
    logic [31:0]   in_stream_tdata;
    logic [3:0]    in_stream_tkeep;
    logic          in_stream_tlast;
    logic          in_stream_tuser;
    logic          in_stream_tvalid;
    logic          in_stream_tready;
    logic          enable_i;
    logic          clear_i;
    logic          frame_done_o;
    logic [CW-1:0] frame_count_o;
    logic [CW-1:0] error_count_o;
    logic [3:0]    err_flags_o;
    logic          in_frame_o;
    logic [31:0]   frame_sum_o;

    axis_frame_sink #(.WORDS_PER_LINE(WPL), .LINES(NL), .CNT_W(CW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .enable_i         (enable_i),
        .clear_i          (clear_i),
        .frame_done_o     (frame_done_o),
        .frame_count_o    (frame_count_o),
        .error_count_o    (error_count_o),
        .err_flags_o      (err_flags_o),
        .in_frame_o       (in_frame_o),
        .frame_sum_o      (frame_sum_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is a run of FW words indexed 0..FW-1 from SOF.
    bit            m_active;
    int            m_pos;
    logic [31:0]   m_sum;
    logic [31:0]   m_fsum;
    logic [CW-1:0] m_frames;
    logic [CW-1:0] m_errs;
    logic [3:0]    m_flags;
    bit            m_done;
    bit            m_ready;

    function automatic void m_reset();
        m_active = 0; m_pos = 0; m_sum = '0; m_fsum = '0;
        m_frames = '0; m_errs = '0; m_flags = '0; m_done = 0; m_ready = 0;
    endfunction

    function automatic void m_error(int b);
        m_flags[b] = 1'b1;
        if (m_errs != {CW{1'b1}}) m_errs = m_errs + 1'b1;
    endfunction

    function automatic void m_word(logic [31:0] d, bit u, bit l, logic [3:0] k);
        bit eol_due;
        if (!m_active) begin
            if (!u) return;
            if (l) begin m_error(ERR_EARLY_EOL); return; end
            m_active = 1; m_pos = 1; m_sum = d;
            return;
        end
        if (u) begin m_error(ERR_UNEXP_SOF); m_pos = 1; m_sum = d; return; end
        if (k != 4'hF) begin m_error(ERR_BAD_KEEP); m_active = 0; return; end
        eol_due = (m_pos % WPL) == WPL - 1;
        if (l && !eol_due) begin m_error(ERR_EARLY_EOL); m_active = 0; return; end
        if (!l && eol_due) begin m_error(ERR_LATE_EOL); m_active = 0; return; end
        m_pos++;
        m_sum = m_sum + d;
        if (m_pos == FW) begin
            m_frames = m_frames + 1'b1;
            m_done   = 1;
            m_fsum   = m_sum;
            m_active = 0;
        end
    endfunction

    function automatic logic [31:0] exp_fsum(logic [31:0] v);
`ifdef AXIS_SINK_CHECKSUM_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic compare_all(input string where);
        check({where, "/tready"},   32'(in_stream_tready), 32'(m_ready));
        check({where, "/done"},     32'(frame_done_o),     32'(m_done));
        check({where, "/frames"},   32'(frame_count_o),    32'(m_frames));
        check({where, "/errors"},   32'(error_count_o),    32'(m_errs));
        check({where, "/flags"},    32'(err_flags_o),      32'(m_flags));
        check({where, "/in_frame"}, 32'(in_frame_o),       32'(m_active));
        check({where, "/sum"},      frame_sum_o,           exp_fsum(m_fsum));
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit u, input bit l,
                        input logic [3:0] k, input bit clr, input bit en, output bit acc);
        @(negedge aclk);
        in_stream_tvalid = v;
        in_stream_tdata  = d;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tkeep  = k;
        clear_i          = clr;
        enable_i         = en;
        acc = v && in_stream_tready;
        @(posedge aclk);
        #1;
        m_done = 0;
        if (acc) m_word(d, u, l, k);
        if (clr) begin m_frames = '0; m_errs = '0; m_flags = '0; end
        m_ready = en;
        if (frame_done_o) n_done++;
        compare_all("step");
    endtask

    task automatic idle(input int n, input bit clr);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, 4'hF, clr && i == 0, 1'b1, acc);
    endtask

    task automatic send_word(input logic [31:0] d, input bit u, input bit l, input logic [3:0] k,
                             input bit rnd);
        bit acc;
        bit clr;
        acc = 0;
        if (rnd) idle($urandom_range(0, 2), 1'b0);
        for (int t = 0; t < 64 && !acc; t++) begin
            clr = rnd && ($urandom_range(0, 63) == 0);
            step(1'b1, d, u, l, k, clr, rnd ? 1'($urandom) : 1'b1, acc);
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_range(input int first, input int last, input logic [31:0] d, input bit rnd);
        for (int i = first; i <= last; i++)
            send_word(d, i == 0, (i % WPL) == WPL - 1, 4'hF, rnd);
    endtask

    task automatic start_case();
        idle(2, 1'b1);
        n_done = 0;
    endtask

    task automatic apply_reset();
        aresetn          = 1'b0;
        in_stream_tvalid = 1'b0;
        #1;
        m_reset();
        compare_all("reset_async");
        repeat (2) @(negedge aclk);
        compare_all("reset_hold");
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; in_stream_tvalid = 1'b0; in_stream_tdata = '0; in_stream_tkeep = 4'hF;
        in_stream_tlast = 1'b0; in_stream_tuser = 1'b0; enable_i = 1'b0; clear_i = 1'b0;
        m_reset();
        #12;
        compare_all("por");
        check("por_tready", 32'(in_stream_tready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Clean frame of twelve ones.
        start_case();
        send_range(0, FW - 1, 32'd1, 1'b0);
        idle(1, 1'b0);
        check("clean_count", 32'(frame_count_o), 32'd1);
        check("clean_flags", 32'(err_flags_o), 32'd0);
        check("clean_done_pulses", 32'(n_done), 32'd1);
        check("clean_sum", frame_sum_o, exp_fsum(32'd12));

        // Early end of line on the second word of the first line.
        start_case();
        send_word(32'd1, 1'b1, 1'b0, 4'hF, 1'b0);
        send_word(32'd1, 1'b0, 1'b1, 4'hF, 1'b0);
        check("early_flags", 32'(err_flags_o), 32'b0001);
        check("early_errcnt", 32'(error_count_o), 32'd1);
        check("early_in_frame", 32'(in_frame_o), 32'd0);
        send_range(0, FW - 1, 32'd1, 1'b0);
        idle(1, 1'b0);
        check("early_then_clean", 32'(frame_count_o), 32'd1);

        // Unexpected SOF on the sixth word restarts the frame.
        start_case();
        send_range(0, 4, 32'd1, 1'b0);
        send_range(0, FW - 1, 32'd1, 1'b0);
        idle(1, 1'b0);
        check("usof_flag", 32'(err_flags_o[ERR_UNEXP_SOF]), 32'd1);
        check("usof_count", 32'(frame_count_o), 32'd1);
        check("usof_sum", frame_sum_o, exp_fsum(32'd12));

        // Junk before SOF is silently discarded.
        start_case();
        for (int i = 0; i < 3; i++) send_word(32'hDEAD0000 + 32'(i), 1'b0, i == 2, 4'hF, 1'b0);
        send_range(0, FW - 1, 32'd1, 1'b0);
        idle(1, 1'b0);
        check("junk_count", 32'(frame_count_o), 32'd1);
        check("junk_errcnt", 32'(error_count_o), 32'd0);

        // Random backpressure must neither drop nor repeat words.
        start_case();
        send_range(0, FW - 1, 32'd1, 1'b1);
        idle(1, 1'b0);
        check("bp_count", 32'(frame_count_o), 32'd1);
        check("bp_done_pulses", 32'(n_done), 32'd1);
        check("bp_sum", frame_sum_o, exp_fsum(32'd12));

        // Reset mid-frame after the seventh word.
        start_case();
        send_range(0, 6, 32'd1, 1'b0);
        apply_reset();
        check("rst_in_frame", 32'(in_frame_o), 32'd0);
        send_range(7, FW - 1, 32'd1, 1'b0);
        send_range(0, FW - 1, 32'd1, 1'b0);
        idle(1, 1'b0);
        check("rst_count", 32'(frame_count_o), 32'd1);
        check("rst_errcnt", 32'(error_count_o), 32'd0);

        // Back-to-back frames with no gap.
        start_case();
        send_range(0, FW - 1, 32'd3, 1'b0);
        send_range(0, FW - 1, 32'd5, 1'b0);
        idle(1, 1'b0);
        check("b2b_count", 32'(frame_count_o), 32'd2);
        check("b2b_sum", frame_sum_o, exp_fsum(32'd60));

        // Randomized frames with corruption, gaps, backpressure and clears.
        start_case();
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < FW; i++) begin
                bit u = (i == 0);
                bit l = (i % WPL) == WPL - 1;
                logic [3:0] k = 4'hF;
                int sel = $urandom_range(0, 39);
                if (i != 0) begin
                    if (sel == 0) u = 1'b1;
                    else if (sel == 1) k = 4'($urandom_range(0, 14));
                    else if (sel == 2) l = ~l;
                end
                if (sel == 3) begin
                    send_word($urandom, 1'b0, 1'($urandom), 4'hF, 1'b1);
                end
                send_word($urandom, u, l, k, 1'b1);
            end
        end
        idle(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
